// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch bus slave: grants requests up to an outstanding limit and
// answers in order after a fixed latency, flagging address errors.
module ibex_instr_mem_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned NUM_OUTSTANDING = 2,
    parameter int unsigned LATENCY         = 1,
    parameter logic [31:0] ERR_BASE        = 32'hFFFF_FFFF,
    parameter logic [31:0] ERR_MASK        = 32'h0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [31:0]                  instr_rdata_o,
    output logic                         instr_err_o,
    input  logic                         gnt_stall_i,
    input  logic                         load_en_i,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
    input  logic [31:0]                  load_data_i,
    output logic [2:0]                   outstanding_o
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = 3;

    logic [CNT_W-1:0] count_q;
    logic             gnt;
    logic [IDX_W-1:0] req_idx;
    logic             req_err;

    logic             head_valid;
    logic [IDX_W-1:0] head_idx;
    logic             head_err;

    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic             rerr_q;

    logic [31:0]      mem [MEM_WORDS];

    assign req_idx = instr_addr_i[IDX_W+1:2];
    assign req_err = (instr_addr_i[1:0] != 2'b00)
                   | (instr_addr_i[31:IDX_W+2] != '0)
                   | ((instr_addr_i & ERR_MASK) == ERR_BASE);

    // A slot freed by this cycle's response may be reused in the same cycle.
    assign gnt = instr_req_i & ~gnt_stall_i & ~rst_i
               & ((count_q - CNT_W'(rvalid_q)) < CNT_W'(NUM_OUTSTANDING));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(gnt) - CNT_W'(rvalid_q);
        end
    end

    // Delay line feeding the output register; the output register is the last stage.
    if (LATENCY == 1) begin : g_direct
        assign head_valid = gnt;
        assign head_idx   = req_idx;
        assign head_err   = req_err;
    end else begin : g_pipe
        localparam int unsigned DEPTH = LATENCY - 1;

        logic [DEPTH-1:0] stg_valid_q;
        logic [DEPTH-1:0] stg_err_q;
        logic [IDX_W-1:0] stg_idx_q [DEPTH];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stg_valid_q <= '0;
            end else begin
                stg_valid_q[0] <= gnt;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stg_valid_q[i] <= stg_valid_q[i-1];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (gnt) begin
                stg_idx_q[0] <= req_idx;
                stg_err_q[0] <= req_err;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stg_idx_q[i] <= stg_idx_q[i-1];
                stg_err_q[i] <= stg_err_q[i-1];
            end
        end

        assign head_valid = stg_valid_q[DEPTH-1];
        assign head_idx   = stg_idx_q[DEPTH-1];
        assign head_err   = stg_err_q[DEPTH-1];
    end

    // Memory is sampled as the response is produced, so a same-edge preload sees old data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= head_valid;
            rerr_q   <= head_valid & head_err;
            rdata_q  <= (head_valid && !head_err) ? mem[head_idx] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_en_i) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    assign instr_gnt_o    = gnt;
    assign instr_rvalid_o = rvalid_q;
    assign instr_rdata_o  = rdata_q;
    assign instr_err_o    = rerr_q;
    assign outstanding_o  = count_q;

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Bench for ibex_instr_mem_responder: two configurations share one stimulus
// stream; vector table, directed corner sequences, then random vs a schedule model.
module tb_ibex_instr_mem_responder;

    localparam int unsigned MW = 64;
    localparam int unsigned N0 = 2;
    localparam int unsigned L0 = 2;
    localparam int unsigned N1 = 1;
    localparam int unsigned L1 = 3;
    localparam logic [31:0] B0 = 32'h8000_0000;
    localparam logic [31:0] M0 = 32'hF000_0000;
    localparam logic [31:0] B1 = 32'h0000_0040;
    localparam logic [31:0] M1 = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst, req, stall, load_en;
    logic [31:0] addr, load_data;
    logic [5:0]  load_addr;

    logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
    logic [31:0] rdata0, rdata1;
    logic [2:0]  out0, out1;

    int errors = 0;
    int checks = 0;
    logic [31:0] mm [MW];

    always #5 clk = ~clk;

    ibex_instr_mem_responder #(
        .MEM_WORDS(MW), .NUM_OUTSTANDING(N0), .LATENCY(L0), .ERR_BASE(B0), .ERR_MASK(M0)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt0), .instr_rvalid_o(rvalid0), .instr_rdata_o(rdata0),
        .instr_err_o(err0), .gnt_stall_i(stall), .load_en_i(load_en),
        .load_addr_i(load_addr), .load_data_i(load_data), .outstanding_o(out0)
    );

    ibex_instr_mem_responder #(
        .MEM_WORDS(MW), .NUM_OUTSTANDING(N1), .LATENCY(L1), .ERR_BASE(B1), .ERR_MASK(M1)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt1), .instr_rvalid_o(rvalid1), .instr_rdata_o(rdata1),
        .instr_err_o(err1), .gnt_stall_i(stall), .load_en_i(load_en),
        .load_addr_i(load_addr), .load_data_i(load_data), .outstanding_o(out1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) tick();
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    function automatic bit exp_err(input int d, input logic [31:0] a);
        logic [31:0] b;
        logic [31:0] m;
        b = (d == 0) ? B0 : B1;
        m = (d == 0) ? M0 : M1;
        return (a[1:0] != 2'b00) || (32'(a[31:2]) >= MW) || ((a & m) == b);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            6:       a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
            7:       a = 32'h100 + (32'($urandom_range(0, 255)) << 2);
            8:       a = 32'h40 | (32'($urandom_range(0, 3)) << 2);
            9:       a = $urandom;
            default: a = 32'($urandom_range(0, 63)) << 2;
        endcase
        return a;
    endfunction

    // Model: responses scheduled by absolute due cycle.
    bit          sv [2][64];
    bit          se [2][64];
    logic [5:0]  si [2][64];
    logic [31:0] sd [2][64];
    int          cnt [2];

    task automatic model_cycle(input int c);
        int s, ns, n1, lim, lat;
        bit rv, eg;
        logic [31:0] ag, arv, aer, ard, aout;
        for (int d = 0; d < 2; d++) begin
            s   = c % 64;
            lim = (d == 0) ? int'(N0) : int'(N1);
            lat = (d == 0) ? int'(L0) : int'(L1);
            rv  = sv[d][s];
            eg  = req && !stall && !rst && ((cnt[d] - int'(rv)) < lim);
            ag   = 32'((d == 0) ? gnt0 : gnt1);
            arv  = 32'((d == 0) ? rvalid0 : rvalid1);
            aer  = 32'((d == 0) ? err0 : err1);
            ard  = (d == 0) ? rdata0 : rdata1;
            aout = 32'((d == 0) ? out0 : out1);
            chk($sformatf("rnd%0d_c%0d_gnt", d, c), ag, 32'(eg));
            chk($sformatf("rnd%0d_c%0d_rvalid", d, c), arv, 32'(rv));
            chk($sformatf("rnd%0d_c%0d_err", d, c), aer, 32'(rv && se[d][s]));
            chk($sformatf("rnd%0d_c%0d_rdata", d, c), ard, rv ? sd[d][s] : 32'h0);
            chk($sformatf("rnd%0d_c%0d_outst", d, c), aout, 32'(cnt[d]));
            if (rst) begin
                for (int j = 0; j < 64; j++) sv[d][j] = 1'b0;
                cnt[d] = 0;
            end else begin
                if (rv) begin
                    sv[d][s] = 1'b0;
                    cnt[d]--;
                end
                if (eg) begin
                    ns = (c + lat) % 64;
                    sv[d][ns] = 1'b1;
                    se[d][ns] = exp_err(d, addr);
                    si[d][ns] = addr[7:2];
                    cnt[d]++;
                end
                n1 = (c + 1) % 64;
                if (sv[d][n1]) sd[d][n1] = se[d][n1] ? 32'h0 : mm[si[d][n1]];
            end
        end
        if (load_en) mm[load_addr] = load_data;
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          err0;
        bit          err1;
        logic [31:0] data0;
        logic [31:0] data1;
    } vec_t;

    vec_t vt [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = 1'b0; stall = 1'b0; load_en = 1'b0;
        addr = '0; load_addr = '0; load_data = '0;
        tick();

        // Preload during reset, with a request that must not be granted.
        req = 1'b1;
        addr = 32'h10;
        for (int i = 0; i < int'(MW); i++) begin
            mm[i] = (i == 4) ? 32'h0000_0513 : (i == 5) ? 32'h0040_0593 : pat(i);
            load_en = 1'b1;
            load_addr = 6'(i);
            load_data = mm[i];
            if (i == 0) begin
                @(negedge clk);
                chk("rst_gnt0", 32'(gnt0), 32'h0);
                chk("rst_gnt1", 32'(gnt1), 32'h0);
                chk("rst_rvalid0", 32'(rvalid0), 32'h0);
                chk("rst_rdata0", rdata0, 32'h0);
                chk("rst_err0", 32'(err0), 32'h0);
                chk("rst_out0", 32'(out0), 32'h0);
                chk("rst_rvalid1", 32'(rvalid1), 32'h0);
                chk("rst_out1", 32'(out1), 32'h0);
            end
            tick();
        end
        load_en = 1'b0;
        req = 1'b0;
        rst = 1'b0;
        tick();

        vt[0] = '{32'h0000_0010, 1'b0, 1'b0, 32'h0000_0513, 32'h0000_0513};
        vt[1] = '{32'h0000_0014, 1'b0, 1'b0, 32'h0040_0593, 32'h0040_0593};
        vt[2] = '{32'h0000_0002, 1'b1, 1'b1, 32'h0, 32'h0};
        vt[3] = '{32'h0000_0100, 1'b1, 1'b1, 32'h0, 32'h0};
        vt[4] = '{32'h8000_0010, 1'b1, 1'b1, 32'h0, 32'h0};
        vt[5] = '{32'h0000_0044, 1'b0, 1'b1, pat(17), 32'h0};
        vt[6] = '{32'h0000_00FC, 1'b0, 1'b0, pat(63), pat(63)};
        vt[7] = '{32'h0000_0050, 1'b0, 1'b0, pat(20), pat(20)};

        foreach (vt[i]) begin
            req = 1'b1;
            addr = vt[i].addr;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt0", i), 32'(gnt0), 32'h1);
            chk($sformatf("vec%0d_gnt1", i), 32'(gnt1), 32'h1);
            tick();
            req = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_early0", i), 32'(rvalid0), 32'h0);
            tick();
            @(negedge clk);
            chk($sformatf("vec%0d_rvalid0", i), 32'(rvalid0), 32'h1);
            chk($sformatf("vec%0d_err0", i), 32'(err0), 32'(vt[i].err0));
            chk($sformatf("vec%0d_rdata0", i), rdata0, vt[i].data0);
            tick();
            @(negedge clk);
            chk($sformatf("vec%0d_rvalid1", i), 32'(rvalid1), 32'h1);
            chk($sformatf("vec%0d_err1", i), 32'(err1), 32'(vt[i].err1));
            chk($sformatf("vec%0d_rdata1", i), rdata1, vt[i].data1);
            chk($sformatf("vec%0d_single0", i), 32'(rvalid0), 32'h0);
            tick();
        end

        // Back-to-back fetches on the L=2, N=2 instance.
        req = 1'b1;
        addr = 32'h10;
        @(negedge clk);
        chk("b2b_gnt_a", 32'(gnt0), 32'h1);
        tick();
        addr = 32'h14;
        @(negedge clk);
        chk("b2b_gnt_b", 32'(gnt0), 32'h1);
        chk("b2b_gnt1_blocked", 32'(gnt1), 32'h0);
        tick();
        req = 1'b0;
        @(negedge clk);
        chk("b2b_rvalid_a", 32'(rvalid0), 32'h1);
        chk("b2b_rdata_a", rdata0, 32'h0000_0513);
        chk("b2b_err_a", 32'(err0), 32'h0);
        tick();
        @(negedge clk);
        chk("b2b_rvalid_b", 32'(rvalid0), 32'h1);
        chk("b2b_rdata_b", rdata0, 32'h0040_0593);
        tick();
        @(negedge clk);
        chk("b2b_done", 32'(rvalid0), 32'h0);
        idle(4);

        // Held request on the N=1, L=3 instance: grants every third cycle.
        req = 1'b1;
        addr = 32'h20;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk($sformatf("hold_k%0d_gnt1", k), 32'(gnt1), 32'((k % 3) == 0));
            chk($sformatf("hold_k%0d_out1", k), 32'(out1), (k == 0) ? 32'h0 : 32'h1);
            tick();
        end
        idle(5);

        // Reset while a response is in flight.
        req = 1'b1;
        addr = 32'h14;
        @(negedge clk);
        chk("rmid_gnt0", 32'(gnt0), 32'h1);
        chk("rmid_gnt1", 32'(gnt1), 32'h1);
        tick();
        req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rmid_rvalid0", 32'(rvalid0), 32'h0);
        chk("rmid_out0", 32'(out0), 32'h0);
        chk("rmid_out1", 32'(out1), 32'h0);
        tick();
        @(negedge clk);
        chk("rmid_rvalid1", 32'(rvalid1), 32'h0);
        tick();
        req = 1'b1;
        addr = 32'h10;
        @(negedge clk);
        chk("rmid_new_gnt0", 32'(gnt0), 32'h1);
        tick();
        req = 1'b0;
        tick();
        @(negedge clk);
        chk("rmid_new_rvalid0", 32'(rvalid0), 32'h1);
        chk("rmid_new_rdata0", rdata0, 32'h0000_0513);
        idle(4);

        // Grant stall.
        req = 1'b1;
        addr = 32'h18;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall_k%0d_gnt0", k), 32'(gnt0), 32'h0);
            chk($sformatf("stall_k%0d_gnt1", k), 32'(gnt1), 32'h0);
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("unstall_gnt0", 32'(gnt0), 32'h1);
        chk("unstall_gnt1", 32'(gnt1), 32'h1);
        tick();
        req = 1'b0;
        @(negedge clk);
        chk("unstall_out0", 32'(out0), 32'h1);
        chk("unstall_out1", 32'(out1), 32'h1);
        idle(5);

        // Preload on the edge that produces a response to the same word.
        req = 1'b1;
        addr = 32'h10;
        tick();
        req = 1'b0;
        load_en = 1'b1;
        load_addr = 6'd4;
        load_data = 32'hDEAD_BEEF;
        mm[4] = 32'hDEAD_BEEF;
        tick();
        load_en = 1'b0;
        @(negedge clk);
        chk("rbw_rvalid0", 32'(rvalid0), 32'h1);
        chk("rbw_old_data0", rdata0, 32'h0000_0513);
        tick();
        @(negedge clk);
        chk("rbw_new_data1", rdata1, 32'hDEAD_BEEF);
        tick();
        req = 1'b1;
        addr = 32'h10;
        tick();
        req = 1'b0;
        tick();
        @(negedge clk);
        chk("rbw_next_data0", rdata0, 32'hDEAD_BEEF);
        idle(5);

        // Randomized traffic against the schedule model.
        for (int d = 0; d < 2; d++) begin
            cnt[d] = 0;
            for (int j = 0; j < 64; j++) sv[d][j] = 1'b0;
        end
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req       = ($urandom_range(0, 9) < 7);
            stall     = ($urandom_range(0, 9) < 2);
            addr      = rand_addr();
            load_en   = ($urandom_range(0, 4) == 0);
            load_addr = 6'($urandom_range(0, 63));
            load_data = $urandom;
            @(negedge clk);
            model_cycle(k);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
